// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter
//   Shares one single-port VRAM/palette BRAM between the video pixel fetch
//   path (read-only, fixed priority) and the AXI4-Lite register path
//   (read/write). A starvation counter forces an AXI slot after
//   STARVE_LIMIT consecutive lost conflicts. Read data is routed back to
//   the requester that issued the read through a tag pipeline that matches
//   the BRAM read latency.
//
// Ports
//   axi_aclk, axi_areset        clock, asynchronous active-high reset
//   vid_req_*, vid_addr         video read request handshake
//   vid_rvalid, vid_rdata       video read return (1-cycle pulse, data held)
//   axi_req_*                   AXI-side request handshake, we/addr/wdata/wstrb
//   axi_rvalid, axi_rdata       AXI read return (1-cycle pulse, data held)
//   axi_wdone                   write committed to the BRAM port
//   ram_en/we/addr/wdata        registered BRAM port drive
//   ram_rdata                   BRAM read data, RAM_LAT cycles after ram_en
//
// Optional build macro VRAM_PORT_ARBITER_STATS_EN adds saturating grant and
// forced-slot counters (stat_vid_grants, stat_axi_grants, stat_forced).
//
// FSM states
//   state   | meaning
//   ARB_VID | video has priority, AXI wins only when video is idle
//   ARB_AXI | starvation slot: AXI granted once, video held off

module vram_port_arbiter #(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 32,
  parameter int RAM_LAT      = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  axi_aclk,
  input  logic                  axi_areset,
  input  logic                  vid_req_valid,
  output logic                  vid_req_ready,
  input  logic [ADDR_W-1:0]     vid_addr,
  output logic                  vid_rvalid,
  output logic [DATA_W-1:0]     vid_rdata,
  input  logic                  axi_req_valid,
  output logic                  axi_req_ready,
  input  logic                  axi_req_we,
  input  logic [ADDR_W-1:0]     axi_req_addr,
  input  logic [DATA_W-1:0]     axi_req_wdata,
  input  logic [DATA_W/8-1:0]   axi_req_wstrb,
  output logic                  axi_rvalid,
  output logic [DATA_W-1:0]     axi_rdata,
  output logic                  axi_wdone,
  output logic                  ram_en,
  output logic [DATA_W/8-1:0]   ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata
`ifdef VRAM_PORT_ARBITER_STATS_EN
  ,
  output logic [31:0]           stat_vid_grants,
  output logic [31:0]           stat_axi_grants,
  output logic [15:0]           stat_forced
`endif
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT - 1);

  typedef enum logic {ARB_VID, ARB_AXI} arb_state_t;

  arb_state_t state_q, state_d;
  logic [7:0] starve_q, starve_d;

  logic vid_acc, axi_acc, axi_rd_acc, axi_wr_acc;

  // {valid, is_video} per issued read; index RAM_LAT lines up with ram_rdata
  logic [RAM_LAT:0] tag_valid;
  logic [RAM_LAT:0] tag_vid;

  always_comb begin
    state_d       = state_q;
    starve_d      = starve_q;
    vid_req_ready = 1'b0;
    axi_req_ready = 1'b0;
    case (state_q)
      ARB_VID: begin
        vid_req_ready = vid_req_valid;
        axi_req_ready = axi_req_valid && !vid_req_valid;
        if (!axi_req_valid || axi_req_ready) begin
          starve_d = '0;
        end else if (starve_q == STARVE_MAX) begin
          // conflict again after STARVE_LIMIT-1 losses: next slot is AXI's
          state_d  = ARB_AXI;
          starve_d = '0;
        end else begin
          starve_d = starve_q + 8'd1;
        end
      end
      ARB_AXI: begin
        // one grant (or none if AXI withdrew), then back to video priority
        axi_req_ready = axi_req_valid;
        state_d       = ARB_VID;
        starve_d      = '0;
      end
      default: begin
        state_d  = ARB_VID;
        starve_d = '0;
      end
    endcase
  end

  assign vid_acc    = vid_req_valid && vid_req_ready;
  assign axi_acc    = axi_req_valid && axi_req_ready;
  assign axi_rd_acc = axi_acc && !axi_req_we;
  assign axi_wr_acc = axi_acc && axi_req_we;

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state_q  <= ARB_VID;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      ram_en     <= 1'b0;
      ram_we     <= '0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      axi_wdone  <= 1'b0;
      tag_valid  <= '0;
      tag_vid    <= '0;
      vid_rvalid <= 1'b0;
      axi_rvalid <= 1'b0;
      vid_rdata  <= '0;
      axi_rdata  <= '0;
    end else begin
      ram_en    <= vid_acc || axi_acc;
      ram_we    <= axi_wr_acc ? axi_req_wstrb : {STRB_W{1'b0}};
      axi_wdone <= axi_wr_acc;
      if (vid_acc) begin
        ram_addr <= vid_addr;
      end else if (axi_acc) begin
        ram_addr <= axi_req_addr;
        if (axi_req_we) ram_wdata <= axi_req_wdata;
      end

      tag_valid <= {tag_valid[RAM_LAT-1:0], vid_acc || axi_rd_acc};
      tag_vid   <= {tag_vid[RAM_LAT-1:0], vid_acc};

      vid_rvalid <= tag_valid[RAM_LAT] && tag_vid[RAM_LAT];
      axi_rvalid <= tag_valid[RAM_LAT] && !tag_vid[RAM_LAT];
      if (tag_valid[RAM_LAT] && tag_vid[RAM_LAT])  vid_rdata <= ram_rdata;
      if (tag_valid[RAM_LAT] && !tag_vid[RAM_LAT]) axi_rdata <= ram_rdata;
    end
  end

`ifdef VRAM_PORT_ARBITER_STATS_EN
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      stat_vid_grants <= '0;
      stat_axi_grants <= '0;
      stat_forced     <= '0;
    end else begin
      if (vid_acc && stat_vid_grants != '1) stat_vid_grants <= stat_vid_grants + 32'd1;
      if (axi_acc && stat_axi_grants != '1) stat_axi_grants <= stat_axi_grants + 32'd1;
      if (state_q == ARB_VID && state_d == ARB_AXI && stat_forced != '1)
        stat_forced <= stat_forced + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vram_port_arbiter.sv
// tb_vram_port_arbiter
//   Self-checking bench for vram_port_arbiter: behavioural BRAM with
//   RAM_LAT read latency, a shadow memory giving expected read data, and
//   scoreboard queues for read returns and write completions.
//   Build with +define+VRAM_PORT_ARBITER_STATS_EN to also check the counters.

module tb_vram_port_arbiter;

  localparam int ADDR_W       = 12;
  localparam int DATA_W       = 32;
  localparam int RAM_LAT      = 2;
  localparam int STARVE_LIMIT = 8;

  logic              axi_aclk = 1'b0;
  logic              axi_areset = 1'b1;
  logic              vid_req_valid, vid_req_ready;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_rvalid;
  logic [31:0]       vid_rdata;
  logic              axi_req_valid, axi_req_ready, axi_req_we;
  logic [ADDR_W-1:0] axi_req_addr;
  logic [31:0]       axi_req_wdata;
  logic [3:0]        axi_req_wstrb;
  logic              axi_rvalid;
  logic [31:0]       axi_rdata;
  logic              axi_wdone;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
`ifdef VRAM_PORT_ARBITER_STATS_EN
  logic [31:0]       stat_vid_grants, stat_axi_grants;
  logic [15:0]       stat_forced;
`endif

  always #5 axi_aclk = ~axi_aclk;

  vram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LAT(RAM_LAT), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .axi_aclk(axi_aclk), .axi_areset(axi_areset),
    .vid_req_valid(vid_req_valid), .vid_req_ready(vid_req_ready), .vid_addr(vid_addr),
    .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .axi_req_valid(axi_req_valid), .axi_req_ready(axi_req_ready), .axi_req_we(axi_req_we),
    .axi_req_addr(axi_req_addr), .axi_req_wdata(axi_req_wdata), .axi_req_wstrb(axi_req_wstrb),
    .axi_rvalid(axi_rvalid), .axi_rdata(axi_rdata), .axi_wdone(axi_wdone),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
`ifdef VRAM_PORT_ARBITER_STATS_EN
    ,
    .stat_vid_grants(stat_vid_grants), .stat_axi_grants(stat_axi_grants),
    .stat_forced(stat_forced)
`endif
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge axi_aclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    if (i == 'h010) return 32'h11111111;
    if (i == 'h800) return 32'h00FF00F0;
    return 32'hC0DE0000 | 32'(i);
  endfunction

  // behavioural BRAM
  logic [31:0] mem [4096];
  logic [31:0] rd_pipe [RAM_LAT];
  logic        loaded = 1'b0;

  always @(posedge axi_aclk) begin
    if (!loaded) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_val(i);
      loaded <= 1'b1;
    end else if (ram_en && ram_we != 4'h0) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    rd_pipe[0] <= (ram_en && ram_we == 4'h0) ? mem[ram_addr] : 32'hBAD0BAD0;
    for (int i = 1; i < RAM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_rdata = rd_pipe[RAM_LAT-1];

  // scoreboard
  typedef struct {
    bit          is_vid;
    logic [31:0] data;
    int          due;
  } rd_exp_t;

  rd_exp_t     rd_q[$];
  int          wd_q[$];
  logic [31:0] shadow [4096];
  rd_exp_t     mon_e;
  int          mon_w;

  task automatic note_accept(input bit is_vid, input bit we, input logic [ADDR_W-1:0] addr,
                             input logic [31:0] wd, input logic [3:0] ws);
    rd_exp_t e;
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (ws[b]) shadow[addr][8*b +: 8] = wd[8*b +: 8];
      wd_q.push_back(cyc + 1);
    end else begin
      e.is_vid = is_vid;
      e.data   = shadow[addr];
      e.due    = cyc + RAM_LAT + 2;
      rd_q.push_back(e);
    end
  endtask

  always @(negedge axi_aclk) begin
    if (!axi_areset) begin
      if (vid_rvalid || axi_rvalid) begin
        check("rvalid_both", 64'(vid_rvalid & axi_rvalid), 64'd0);
        if (rd_q.size() == 0) begin
          check("rvalid_unexpected", 64'({vid_rvalid, axi_rvalid}), 64'd0);
        end else begin
          mon_e = rd_q.pop_front();
          check("ret_owner", 64'(vid_rvalid), 64'(mon_e.is_vid));
          check("ret_data", 64'(mon_e.is_vid ? vid_rdata : axi_rdata), 64'(mon_e.data));
          check("ret_cycle", 64'(cyc), 64'(mon_e.due));
        end
      end else if (rd_q.size() != 0 && rd_q[0].due <= cyc) begin
        mon_e = rd_q.pop_front();
        check("ret_missing", 64'({vid_rvalid, axi_rvalid}), mon_e.is_vid ? 64'd2 : 64'd1);
      end
      if (axi_wdone) begin
        if (wd_q.size() == 0) begin
          check("wdone_unexpected", 64'(axi_wdone), 64'd0);
        end else begin
          mon_w = wd_q.pop_front();
          check("wdone_cycle", 64'(cyc), 64'(mon_w));
        end
      end else if (wd_q.size() != 0 && wd_q[0] <= cyc) begin
        mon_w = wd_q.pop_front();
        check("wdone_missing", 64'(axi_wdone), 64'd1);
      end
    end
  end

  // one request cycle: drive after the edge, check ready mid-cycle, log accepts
  task automatic drive_cycle(input string name, input bit vv, input logic [ADDR_W-1:0] va,
                             input bit av, input bit aw, input logic [ADDR_W-1:0] aa,
                             input logic [31:0] awd, input logic [3:0] aws,
                             input bit exp_vr, input bit exp_ar);
    @(posedge axi_aclk); #1;
    vid_req_valid = vv;  vid_addr      = va;
    axi_req_valid = av;  axi_req_we    = aw;  axi_req_addr = aa;
    axi_req_wdata = awd; axi_req_wstrb = aws;
    @(negedge axi_aclk);
    check({name, "_vid_rdy"}, 64'(vid_req_ready), 64'(exp_vr));
    check({name, "_axi_rdy"}, 64'(axi_req_ready), 64'(exp_ar));
    if (vv && vid_req_ready) note_accept(1'b1, 1'b0, va, 32'h0, 4'h0);
    if (av && axi_req_ready) note_accept(1'b0, aw, aa, awd, aws);
  endtask

  task automatic idle(input int n);
    @(posedge axi_aclk); #1;
    vid_req_valid = 1'b0;
    axi_req_valid = 1'b0;
    repeat (n - 1) @(posedge axi_aclk);
    @(negedge axi_aclk);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_readys"}, 64'({vid_req_ready, axi_req_ready}), 64'd0);
    check({name, "_pulses"}, 64'({vid_rvalid, axi_rvalid, axi_wdone}), 64'd0);
    check({name, "_ram_ctl"}, 64'({ram_en, ram_we, ram_addr}), 64'd0);
    check({name, "_ram_wdata"}, 64'(ram_wdata), 64'd0);
    check({name, "_rdata"}, {vid_rdata, axi_rdata}, 64'd0);
  endtask

  typedef struct {
    bit                vv;
    bit                av;
    bit                aw;
    logic [ADDR_W-1:0] va;
    logic [ADDR_W-1:0] aa;
    logic [31:0]       wd;
    bit                evr;
    bit                ear;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int vaddr;
    int k;
    bit axi_pend;
    int t;
`ifdef VRAM_PORT_ARBITER_STATS_EN
    logic [15:0] forced0;
`endif

    vecs[0] = '{vv:0, av:0, aw:0, va:12'h000, aa:12'h000, wd:32'h0,        evr:0, ear:0};
    vecs[1] = '{vv:1, av:0, aw:0, va:12'h040, aa:12'h000, wd:32'h0,        evr:1, ear:0};
    vecs[2] = '{vv:0, av:1, aw:0, va:12'h000, aa:12'h030, wd:32'h0,        evr:0, ear:1};
    vecs[3] = '{vv:1, av:1, aw:0, va:12'h041, aa:12'h031, wd:32'h0,        evr:1, ear:0};
    vecs[4] = '{vv:0, av:1, aw:1, va:12'h000, aa:12'h031, wd:32'h12345678, evr:0, ear:1};
    vecs[5] = '{vv:1, av:1, aw:0, va:12'h031, aa:12'h031, wd:32'h0,        evr:1, ear:0};
    vecs[6] = '{vv:1, av:0, aw:0, va:12'h042, aa:12'h000, wd:32'h0,        evr:1, ear:0};
    vecs[7] = '{vv:0, av:0, aw:0, va:12'h000, aa:12'h000, wd:32'h0,        evr:0, ear:0};

    for (int i = 0; i < 4096; i++) shadow[i] = init_val(i);
    vid_req_valid = 1'b0; vid_addr = '0;
    axi_req_valid = 1'b0; axi_req_we = 1'b0; axi_req_addr = '0;
    axi_req_wdata = '0;   axi_req_wstrb = '0;

    axi_areset = 1'b1;
    repeat (3) @(negedge axi_aclk);
    check_all_zero("reset");
    @(posedge axi_aclk); #1;
    axi_areset = 1'b0;
    idle(2);

    // isolated AXI write then read
    drive_cycle("iso_wr", 1'b0, 12'h0, 1'b1, 1'b1, 12'h005, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1);
    drive_cycle("iso_rd", 1'b0, 12'h0, 1'b1, 1'b0, 12'h005, 32'h0, 4'h0, 1'b0, 1'b1);
    idle(6);
    check("iso_rdata_hold", 64'(axi_rdata), 64'h00000000DEADBEEF);

    // table vectors
    for (int i = 0; i < 8; i++)
      drive_cycle($sformatf("vec%0d", i), vecs[i].vv, vecs[i].va, vecs[i].av, vecs[i].aw,
                  vecs[i].aa, vecs[i].wd, 4'hF, vecs[i].evr, vecs[i].ear);
    idle(6);

    // video priority with starvation slot on the 9th conflict cycle
`ifdef VRAM_PORT_ARBITER_STATS_EN
    forced0 = stat_forced;
`endif
    vaddr = 0;
    k = 0;
    axi_pend = 1'b1;
    while (vaddr < 16 && k < 40) begin
      k++;
      drive_cycle($sformatf("prio%0d", k), 1'b1, vaddr[ADDR_W-1:0], axi_pend, 1'b0, 12'h005,
                  32'h0, 4'h0, k != STARVE_LIMIT + 1, k == STARVE_LIMIT + 1);
      if (axi_pend && axi_req_ready) axi_pend = 1'b0;
      if (vid_req_ready) vaddr++;
    end
    check("prio_axi_served", 64'(axi_pend), 64'd0);
    idle(6);
`ifdef VRAM_PORT_ARBITER_STATS_EN
    check("stat_forced_delta", 64'(stat_forced - forced0), 64'd1);
`endif

    // interleaved back-to-back video / AXI reads
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0)
        drive_cycle("ilv_vid", 1'b1, 12'h010, 1'b0, 1'b0, 12'h800, 32'h0, 4'h0, 1'b1, 1'b0);
      else
        drive_cycle("ilv_axi", 1'b0, 12'h010, 1'b1, 1'b0, 12'h800, 32'h0, 4'h0, 1'b0, 1'b1);
    end
    idle(6);
    check("ilv_vid_hold", 64'(vid_rdata), 64'h0000000011111111);
    check("ilv_axi_hold", 64'(axi_rdata), 64'h0000000000FF00F0);

    // byte strobes
    drive_cycle("strb_clr", 1'b0, 12'h0, 1'b1, 1'b1, 12'h020, 32'h00000000, 4'hF, 1'b0, 1'b1);
    drive_cycle("strb_wr",  1'b0, 12'h0, 1'b1, 1'b1, 12'h020, 32'hAABBCCDD, 4'h5, 1'b0, 1'b1);
    drive_cycle("strb_rd",  1'b0, 12'h0, 1'b1, 1'b0, 12'h020, 32'h0, 4'h0, 1'b0, 1'b1);
    idle(6);
    check("strb_rdata", 64'(axi_rdata), 64'h0000000000BB00DD);

    // reset one cycle after a video read accept
    drive_cycle("rst_vid", 1'b1, 12'h003, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0, 1'b1, 1'b0);
    @(posedge axi_aclk); #1;
    vid_req_valid = 1'b0;
    axi_req_valid = 1'b0;
    axi_areset = 1'b1;
    rd_q.delete();
    wd_q.delete();
    @(negedge axi_aclk);
    check_all_zero("rst_mid");
    repeat (2) @(negedge axi_aclk);
    check_all_zero("rst_hold");
    @(posedge axi_aclk); #1;
    axi_areset = 1'b0;
    idle(8);
    drive_cycle("post_rst", 1'b1, 12'h004, 1'b1, 1'b0, 12'h006, 32'h0, 4'h0, 1'b1, 1'b0);
    idle(8);

    t = 0;
    while ((rd_q.size() != 0 || wd_q.size() != 0) && t < 50) begin
      @(negedge axi_aclk);
      t++;
    end
    check("drain_outstanding", 64'(rd_q.size() + wd_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
